seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/hex_to_seg7.sv | 35 +++
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the eight-digit seven-segment scan driver.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
//   - Blank pattern and all-anodes-off value.
//   - Digit and phase counter widths.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;
  localparam int PHASE_W    = 3;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment pattern.
//   nibble  in  4  hex value 0..F
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Nibble lookup into the shared pattern table.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode
// seven-segment display with frame-synchronous capture, per-half leading-zero
// blanking, 8-level brightness PWM and a one-cycle anti-ghosting guard.
//   Clk         in  1   system clock
//   Reset       in  1   asynchronous active-low reset
//   value_hi    in  16  left word, digits 7..4
//   value_lo    in  16  right word, digits 3..0
//   load        in  1   capture request (may be held high)
//   dim         in  3   brightness, anode on for (dim+1)/8 of each slot
//   out7        out 7   segments {g,f,e,d,c,b,a}, active-low
//   en_out      out 8   anodes, bit i = digit i, active-low
//   frame_done  out 1   one-cycle pulse after digit 7's slot ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] value_hi,
  input  logic [15:0] value_lo,
  input  logic        load,
  input  logic [2:0]  dim,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        frame_done
);

  // Each digit slot is split into 8 PWM phases of SUB_COUNT cycles each.
  localparam int SUB_COUNT = REFRESH_DIV / 8;
  localparam int SUB_W     = $clog2(SUB_COUNT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_COUNT - 1);

  logic [SUB_W-1:0] sub_r;
  phase_t           phase_r;
  digit_t           digit_r;
  logic [15:0]      shadow_hi_r;
  logic [15:0]      shadow_lo_r;
  logic             pending_r;

  logic             boundary_s;
  logic [15:0]      half_word_s;
  logic [3:0]       nibble_s;
  logic             upper_zero_s;
  logic             blank_s;
  logic             guard_s;
  logic             an_on_s;
  logic [6:0]       seg_s;
  logic [7:0]       en_next_s;
  logic [6:0]       seg_next_s;

  assign boundary_s = (digit_r == 3'd7) && (phase_r == 3'd7) && (sub_r == SUB_LAST);

  // Scan counters: sub -> phase -> digit, each wrapping silently.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sub_r   <= '0;
      phase_r <= '0;
      digit_r <= '0;
    end else if (sub_r == SUB_LAST) begin
      sub_r   <= '0;
      phase_r <= phase_r + 3'd1;
      if (phase_r == 3'd7) begin
        digit_r <= digit_r + 3'd1;
      end else begin
        digit_r <= digit_r;
      end
    end else begin
      sub_r   <= sub_r + SUB_W'(1);
      phase_r <= phase_r;
      digit_r <= digit_r;
    end
  end

  // Frame-synchronous capture; a load in the boundary cycle itself is taken
  // directly, so pending only has to remember requests made mid-frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shadow_hi_r <= 16'h0000;
      shadow_lo_r <= 16'h0000;
      pending_r   <= 1'b0;
    end else if (boundary_s && (pending_r || load)) begin
      shadow_hi_r <= value_hi;
      shadow_lo_r <= value_lo;
      pending_r   <= 1'b0;
    end else if (load) begin
      pending_r   <= 1'b1;
    end else begin
      pending_r   <= pending_r;
    end
  end

  // Select the current nibble and decide whether it is a leading zero of its
  // half: blanked when this and every more-significant nibble are zero.
  always_comb begin
    half_word_s  = digit_r[2] ? shadow_hi_r : shadow_lo_r;
    nibble_s     = 4'h0;
    upper_zero_s = 1'b0;
    case (digit_r[1:0])
      2'd0: begin
        nibble_s     = half_word_s[3:0];
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nibble_s     = half_word_s[7:4];
        upper_zero_s = (half_word_s[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s     = half_word_s[11:8];
        upper_zero_s = (half_word_s[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s     = half_word_s[15:12];
        upper_zero_s = (half_word_s[15:12] == 4'h0);
      end
      default: begin
        nibble_s     = 4'h0;
        upper_zero_s = 1'b0;
      end
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_s),
    .seg    (seg_s)
  );

  // Anode gating: PWM duty, blanking and the first cycle of every slot as a
  // dead cycle so the previous digit's pattern never ghosts onto this one.
  always_comb begin
    blank_s = BLANK_LZ && upper_zero_s;
    guard_s = (phase_r == 3'd0) && (sub_r == '0);
    an_on_s = (phase_r <= dim) && !blank_s && !guard_s;
    if (an_on_s) begin
      en_next_s  = ~(8'h01 << digit_r);
      seg_next_s = seg_s;
    end else begin
      en_next_s  = AN_OFF;
      seg_next_s = SEG_BLANK;
    end
  end

  // Output registers; frame_done lands on the same edge the capture applies.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      en_out     <= AN_OFF;
      out7       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      en_out     <= en_next_s;
      out7       <= seg_next_s;
      frame_done <= boundary_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// REFRESH_DIV=16 (16-cycle slots, 128-cycle frames).
module tb_seg7_scan_driver;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] value_hi;
  logic [15:0] value_lo;
  logic        load;
  logic [2:0]  dim;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        frame_done;

  always #5 Clk = ~Clk;

  seg7_scan_driver #(.REFRESH_DIV(16), .BLANK_LZ(1'b1)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .value_hi   (value_hi),
    .value_lo   (value_lo),
    .load       (load),
    .dim        (dim),
    .out7       (out7),
    .en_out     (en_out),
    .frame_done (frame_done)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] exp_seq [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

  // Reference model state: cycle index since reset release, shadows, pending.
  int          m_t;
  logic [15:0] m_hi;
  logic [15:0] m_lo;
  logic        m_pend;
  logic [15:0] exp_q [$];

  int          cyc;
  int          last_fd;
  int          low_cnt [8];
  logic [6:0]  seen_seg [8];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected registered outputs {en, seg, fd} for the model's current cycle.
  function automatic logic [15:0] model_out();
    int d, ph, p;
    logic [15:0] w, sh;
    logic [3:0]  nib;
    logic [7:0]  e_en;
    logic [6:0]  e_seg;
    logic        blank, on, fd;
    d     = (m_t / 16) % 8;
    ph    = (m_t % 16) / 2;
    w     = (d >= 4) ? m_hi : m_lo;
    p     = d % 4;
    sh    = w >> (4 * p);
    nib   = sh[3:0];
    blank = (p != 0) && (sh == 16'h0000);
    on    = (ph <= int'(dim)) && !blank && ((m_t % 16) != 0);
    fd    = ((m_t % 128) == 127);
    e_en  = 8'hFF;
    e_seg = 7'h7F;
    if (on) begin
      e_en     = 8'hFF;
      e_en[d]  = 1'b0;
      e_seg    = seg_tab[nib];
    end
    return {e_en, e_seg, fd};
  endfunction

  task automatic model_step();
    if (((m_t % 128) == 127) && (m_pend || load)) begin
      m_hi   = value_hi;
      m_lo   = value_lo;
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    m_t++;
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_hi    = 16'h0000;
    m_lo    = 16'h0000;
    m_pend  = 1'b0;
    last_fd = -1;
    exp_q.delete();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 8; i++) begin
      low_cnt[i]  = 0;
      seen_seg[i] = 7'h7F;
    end
  endtask

  // One clock: push expectation, advance model, compare after the edge.
  task automatic tick();
    logic [15:0] got;
    logic [7:0]  inv;
    exp_q.push_back(model_out());
    model_step();
    @(posedge Clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    chk_eq("en_out", en_out, got[15:8]);
    chk_eq("out7", out7, got[7:1]);
    chk_eq("frame_done", frame_done, got[0]);
    inv = ~en_out;
    chk_eq("an_onehot", ($countones(inv) <= 1), 1);
    for (int i = 0; i < 8; i++) begin
      if (!en_out[i]) begin
        low_cnt[i]++;
        seen_seg[i] = out7;
      end
    end
    if (frame_done) begin
      if (last_fd >= 0) chk_eq("fd_period", cyc - last_fd, 128);
      last_fd = cyc;
    end
    @(negedge Clk);
  endtask

  task automatic wait_fd();
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 300) begin
      tick();
      seen = frame_done;
      n++;
    end
    chk_eq("fd_timeout", seen, 1);
  endtask

  task automatic run_frame();
    clear_stats();
    repeat (128) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xval;
    cyc      = 0;
    Reset    = 1'b0;
    load     = 1'b0;
    dim      = 3'd7;
    value_hi = 16'h0000;
    value_lo = 16'h0000;
    model_reset();
    clear_stats();
    @(negedge Clk);
    @(negedge Clk);
    chk_eq("rst_en", en_out, 8'hFF);
    chk_eq("rst_seg", out7, 7'h7F);
    chk_eq("rst_fd", frame_done, 0);
    Reset = 1'b1;
    tick();
    chk_eq("guard_first", en_out, 8'hFF);
    tick();
    chk_eq("first_active_en", en_out, 8'hFE);
    chk_eq("first_active_seg", out7, 7'h40);

    // Main pattern.
    value_hi = 16'h1234;
    value_lo = 16'hABCD;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    wait_fd();
    run_frame();
    for (int i = 0; i < 8; i++) begin
      chk_eq($sformatf("seq_d%0d", i), seen_seg[i], exp_seq[i]);
      chk_eq($sformatf("duty7_d%0d", i), low_cnt[i], 15);
    end

    // Brightness.
    dim = 3'd1;
    run_frame();
    for (int i = 0; i < 8; i++) chk_eq($sformatf("duty1_d%0d", i), low_cnt[i], 3);
    dim = 3'd0;
    run_frame();
    for (int i = 0; i < 8; i++) chk_eq($sformatf("duty0_d%0d", i), low_cnt[i], 1);
    dim = 3'd7;

    // Leading-zero blanking.
    value_hi = 16'h0000;
    value_lo = 16'h00F0;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    wait_fd();
    run_frame();
    chk_eq("lz_d7", low_cnt[7], 0);
    chk_eq("lz_d6", low_cnt[6], 0);
    chk_eq("lz_d5", low_cnt[5], 0);
    chk_eq("lz_d3", low_cnt[3], 0);
    chk_eq("lz_d2", low_cnt[2], 0);
    chk_eq("lz_d4", seen_seg[4], 7'h40);
    chk_eq("lz_d1", seen_seg[1], 7'h0E);
    chk_eq("lz_d0", seen_seg[0], 7'h40);

    // Mid-frame load while value_lo churns during digit 3.
    value_hi = 16'h1234;
    while ((m_t % 128) < 48) tick();
    for (int k = 0; k < 8; k++) begin
      value_lo = 16'($urandom);
      tick();
    end
    xval     = 16'($urandom) | 16'h0001;
    value_lo = xval;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    wait_fd();
    run_frame();
    chk_eq("midload_d0", seen_seg[0], seg_tab[xval[3:0]]);
    chk_eq("midload_d7", seen_seg[7], 7'h79);

    // Load held high: one update per frame.
    load     = 1'b1;
    value_hi = 16'hBEEF;
    wait_fd();
    value_hi = 16'hCAFE;
    run_frame();
    chk_eq("hold_f1_d7", seen_seg[7], 7'h03);
    run_frame();
    chk_eq("hold_f2_d7", seen_seg[7], 7'h46);
    load = 1'b0;

    // Asynchronous reset in the middle of an active slot.
    repeat (5) tick();
    chk_eq("pre_rst_active", en_out, 8'hFE);
    #2;
    Reset = 1'b0;
    #1;
    chk_eq("async_rst_en", en_out, 8'hFF);
    chk_eq("async_rst_seg", out7, 7'h7F);
    chk_eq("async_rst_fd", frame_done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    tick();
    chk_eq("rerst_guard", en_out, 8'hFF);
    tick();
    chk_eq("rerst_active_en", en_out, 8'hFE);
    chk_eq("rerst_active_seg", out7, 7'h40);
    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
